// File: rtl/binary_mul_pipe_pkg.sv
// Shared helpers for the pipelined shift-add multiplier: latency, product width
// and the datapath reset value.
package mul_pkg;

  localparam logic RST_BIT = 1'b0;

  function automatic int mul_latency(input int wb);
    return wb + 1;
  endfunction

  function automatic int prod_w(input int wa, input int wb);
    return wa + wb;
  endfunction

endpackage

// File: rtl/binary_mul_pipe_pp_stage.sv
// One partial-product stage: folds bit b[K] into the accumulator and registers
// the operation's state. The LAST stage doubles as the output register.
module mul_pp_stage
  import mul_pkg::*;
#(
  parameter int WA    = 7,
  parameter int WB    = 7,
  parameter int TAG_W = 4,
  parameter int K     = 0,
  parameter bit LAST  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 prev_valid,
  input  logic                 prev_tc,
  input  logic [TAG_W-1:0]     prev_tag,
  input  logic [WA+WB-1:0]     prev_a_ext,
  input  logic [WB-1:0]        prev_b,
  input  logic [WA+WB-1:0]     prev_acc,
  output logic                 valid,
  output logic                 tc,
  output logic [TAG_W-1:0]     tag,
  output logic [WA+WB-1:0]     a_ext,
  output logic [WB-1:0]        b,
  output logic [WA+WB-1:0]     acc
);

  localparam int PW = prod_w(WA, WB);

  logic [PW-1:0] pp;
  logic [PW-1:0] sum;

  always_comb begin
    pp  = prev_b[K] ? (prev_a_ext << K) : '0;
    // The multiplier MSB carries negative weight in two's-complement mode.
    sum = (LAST && prev_tc) ? (prev_acc - pp) : (prev_acc + pp);
  end

  // NOTE: datapath registers are reset explicitly because the LAST stage's
  // acc/tag are the visible p/out_tag, which must read 0 after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= RST_BIT;
      tc    <= RST_BIT;
      tag   <= {TAG_W{RST_BIT}};
      a_ext <= {PW{RST_BIT}};
      b     <= {WB{RST_BIT}};
      acc   <= {PW{RST_BIT}};
    end else if (en) begin
      valid <= prev_valid;
      // NOTE: inner stages load bubbles freely; the output stage keeps its
      // last result so p/out_tag hold across invalid cycles.
      if (!LAST || prev_valid) begin
        tc    <= prev_tc;
        tag   <= prev_tag;
        a_ext <= prev_a_ext;
        b     <= prev_b;
        acc   <= sum;
      end
    end
  end

endmodule

// File: rtl/binary_mul_pipe.sv
// Fully pipelined WA x WB shift-add multiplier with per-operation signed mode,
// valid/tag pass-through and a global stall; latency WB+1 enabled cycles.
module binary_mul_pipe
  import mul_pkg::*;
#(
  parameter int WA    = 7,
  parameter int WB    = 7,
  parameter int TAG_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               in_valid,
  input  logic               tc,
  input  logic [WA-1:0]      a,
  input  logic [WB-1:0]      b,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  output logic [WA+WB-1:0]   p,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW = prod_w(WA, WB);

  logic             in_valid_q;
  logic             in_tc_q;
  logic [TAG_W-1:0] in_tag_q;
  logic [PW-1:0]    in_a_ext_q;
  logic [WB-1:0]    in_b_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid_q <= RST_BIT;
      in_tc_q    <= RST_BIT;
      in_tag_q   <= {TAG_W{RST_BIT}};
      in_a_ext_q <= {PW{RST_BIT}};
      in_b_q     <= {WB{RST_BIT}};
    end else if (en) begin
      in_valid_q <= in_valid;
      in_tc_q    <= tc;
      in_tag_q   <= in_tag;
      in_a_ext_q <= {{WB{tc & a[WA-1]}}, a};
      in_b_q     <= b;
    end
  end

  logic             prev_valid [WB];
  logic             prev_tc    [WB];
  logic [TAG_W-1:0] prev_tag   [WB];
  logic [PW-1:0]    prev_a_ext [WB];
  logic [WB-1:0]    prev_b     [WB];
  logic [PW-1:0]    prev_acc   [WB];

  logic             st_valid [WB];
  logic             st_tc    [WB];
  logic [TAG_W-1:0] st_tag   [WB];
  logic [PW-1:0]    st_a_ext [WB];
  logic [WB-1:0]    st_b     [WB];
  logic [PW-1:0]    st_acc   [WB];

  for (genvar k = 0; k < WB; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign prev_valid[k] = in_valid_q;
      assign prev_tc[k]    = in_tc_q;
      assign prev_tag[k]   = in_tag_q;
      assign prev_a_ext[k] = in_a_ext_q;
      assign prev_b[k]     = in_b_q;
      assign prev_acc[k]   = {PW{RST_BIT}};
    end else begin : g_link
      assign prev_valid[k] = st_valid[k-1];
      assign prev_tc[k]    = st_tc[k-1];
      assign prev_tag[k]   = st_tag[k-1];
      assign prev_a_ext[k] = st_a_ext[k-1];
      assign prev_b[k]     = st_b[k-1];
      assign prev_acc[k]   = st_acc[k-1];
    end

    mul_pp_stage #(
      .WA(WA), .WB(WB), .TAG_W(TAG_W), .K(k), .LAST(k == WB - 1)
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .en         (en),
      .prev_valid (prev_valid[k]),
      .prev_tc    (prev_tc[k]),
      .prev_tag   (prev_tag[k]),
      .prev_a_ext (prev_a_ext[k]),
      .prev_b     (prev_b[k]),
      .prev_acc   (prev_acc[k]),
      .valid      (st_valid[k]),
      .tc         (st_tc[k]),
      .tag        (st_tag[k]),
      .a_ext      (st_a_ext[k]),
      .b          (st_b[k]),
      .acc        (st_acc[k])
    );
  end

  assign out_valid = st_valid[WB-1];
  assign p         = st_acc[WB-1];
  assign out_tag   = st_tag[WB-1];

endmodule

// File: tb/tb_binary_mul_pipe.sv
// Scoreboard bench for binary_mul_pipe at (7,7), (4,9) and (12,3): directed
// corner vectors, exhaustive 7x7 in both modes, stall, bubble and reset runs.
module tb_binary_mul_pipe;

  logic clk = 1'b0;
  logic rst, en;
  always #5 clk = ~clk;

  logic        in_valid0, tc0, out_valid0;
  logic [6:0]  a0, b0;
  logic [3:0]  tag0, out_tag0;
  logic [13:0] p0;

  logic        in_valid1, tc1, out_valid1;
  logic [3:0]  a1;
  logic [8:0]  b1;
  logic [3:0]  tag1, out_tag1;
  logic [12:0] p1;

  logic        in_valid2, tc2, out_valid2;
  logic [11:0] a2;
  logic [2:0]  b2;
  logic [3:0]  tag2, out_tag2;
  logic [14:0] p2;

  binary_mul_pipe #(.WA(7), .WB(7), .TAG_W(4)) dut0 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid0), .tc(tc0), .a(a0), .b(b0),
    .in_tag(tag0), .out_valid(out_valid0), .p(p0), .out_tag(out_tag0));
  binary_mul_pipe #(.WA(4), .WB(9), .TAG_W(4)) dut1 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid1), .tc(tc1), .a(a1), .b(b1),
    .in_tag(tag1), .out_valid(out_valid1), .p(p1), .out_tag(out_tag1));
  binary_mul_pipe #(.WA(12), .WB(3), .TAG_W(4)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid2), .tc(tc2), .a(a2), .b(b2),
    .in_tag(tag2), .out_valid(out_valid2), .p(p2), .out_tag(out_tag2));

  typedef struct {
    logic [31:0] p;
    logic [3:0]  tag;
    int          edge_n;
  } exp_t;

  typedef struct {
    bit          tc;
    logic [6:0]  a;
    logic [6:0]  b;
    logic [13:0] exp;
  } vec_t;

  exp_t q0[$], q1[$], q2[$];
  exp_t e0, e1, e2;
  int   total = 0, bad = 0;
  int   en_cnt = 0;
  bit   en_s = 1'b0, rst_s = 1'b0;

  task automatic check(input string name, input bit ok, input logic [31:0] act,
                       input logic [31:0] req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic [31:0] ref_mul(input int wa, input int wb, input bit tc,
                                          input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, pr, ma, mb, mp;
    ma = (longint'(1) << wa) - 1;
    mb = (longint'(1) << wb) - 1;
    mp = (longint'(1) << (wa + wb)) - 1;
    sa = longint'(a) & ma;
    sb = longint'(b) & mb;
    if (tc && sa[wa-1]) sa = sa - (longint'(1) << wa);
    if (tc && sb[wb-1]) sb = sb - (longint'(1) << wb);
    pr = (sa * sb) & mp;
    return 32'(pr);
  endfunction

  // Enabled-edge counter: latency is measured in enabled cycles only.
  always @(posedge clk) begin
    en_s  <= en;
    rst_s <= rst;
    if (en) en_cnt <= en_cnt + 1;
  end

  always @(negedge clk) begin
    if (en_s && !rst_s) begin
      if (out_valid0) begin
        if (q0.size() == 0) check("d0_unexpected_out", 1'b0, 32'(p0), 32'h0);
        else begin
          e0 = q0.pop_front();
          check("d0_p", 32'(p0) == e0.p, 32'(p0), e0.p);
          check("d0_tag", out_tag0 == e0.tag, 32'(out_tag0), 32'(e0.tag));
          check("d0_latency", en_cnt == e0.edge_n, en_cnt, e0.edge_n);
        end
      end else if (q0.size() > 0 && q0[0].edge_n <= en_cnt) begin
        e0 = q0.pop_front();
        check("d0_missing_out", 1'b0, 32'(en_cnt), e0.edge_n);
      end
      if (out_valid1) begin
        if (q1.size() == 0) check("d1_unexpected_out", 1'b0, 32'(p1), 32'h0);
        else begin
          e1 = q1.pop_front();
          check("d1_p", 32'(p1) == e1.p, 32'(p1), e1.p);
          check("d1_tag", out_tag1 == e1.tag, 32'(out_tag1), 32'(e1.tag));
          check("d1_latency", en_cnt == e1.edge_n, en_cnt, e1.edge_n);
        end
      end else if (q1.size() > 0 && q1[0].edge_n <= en_cnt) begin
        e1 = q1.pop_front();
        check("d1_missing_out", 1'b0, 32'(en_cnt), e1.edge_n);
      end
      if (out_valid2) begin
        if (q2.size() == 0) check("d2_unexpected_out", 1'b0, 32'(p2), 32'h0);
        else begin
          e2 = q2.pop_front();
          check("d2_p", 32'(p2) == e2.p, 32'(p2), e2.p);
          check("d2_tag", out_tag2 == e2.tag, 32'(out_tag2), 32'(e2.tag));
          check("d2_latency", en_cnt == e2.edge_n, en_cnt, e2.edge_n);
        end
      end else if (q2.size() > 0 && q2[0].edge_n <= en_cnt) begin
        e2 = q2.pop_front();
        check("d2_missing_out", 1'b0, 32'(en_cnt), e2.edge_n);
      end
    end
  end

  // Drives one cycle of dut0 input; capture happens at the next (enabled) edge.
  task automatic d0_op(input bit v, input bit tc, input logic [6:0] a, input logic [6:0] b,
                       input logic [3:0] tag, input logic [31:0] exp);
    @(posedge clk);
    #1;
    in_valid0 = v; tc0 = tc; a0 = a; b0 = b; tag0 = tag;
    if (v) q0.push_back('{exp, tag, en_cnt + 8});
  endtask

  task automatic sweep_op(input bit tcx, input logic [31:0] ra, input logic [31:0] rb,
                          input logic [3:0] tag);
    @(posedge clk);
    #1;
    in_valid1 = 1'b1; tc1 = tcx; a1 = ra[3:0]; b1 = rb[8:0]; tag1 = tag;
    in_valid2 = 1'b1; tc2 = tcx; a2 = ra[11:0]; b2 = rb[2:0]; tag2 = ~tag;
    q1.push_back('{ref_mul(4, 9, tcx, ra, rb), tag, en_cnt + 10});
    q2.push_back('{ref_mul(12, 3, tcx, ra, rb), ~tag, en_cnt + 4});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      in_valid0 = 1'b0; in_valid1 = 1'b0; in_valid2 = 1'b0;
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((q0.size() + q1.size() + q2.size()) > 0 && t < 200) begin
      @(posedge clk);
      t++;
    end
    @(negedge clk);
    check("drain", (q0.size() + q1.size() + q2.size()) == 0,
          32'(q0.size() + q1.size() + q2.size()), 32'h0);
  endtask

  vec_t vt[9];

  initial begin
    vt[0] = '{1'b1, 7'h40, 7'h40, 14'h1000};  // -64 * -64
    vt[1] = '{1'b1, 7'h7F, 7'h01, 14'h3FFF};  // -1 * 1
    vt[2] = '{1'b0, 7'h7F, 7'h7F, 14'h3F01};  // 127 * 127
    vt[3] = '{1'b0, 7'h7F, 7'h01, 14'd127};
    vt[4] = '{1'b0, 7'h00, 7'h55, 14'h0000};
    vt[5] = '{1'b1, 7'h00, 7'h7F, 14'h0000};
    vt[6] = '{1'b1, 7'h40, 7'h3F, 14'h3040};  // -64 * 63
    vt[7] = '{1'b1, 7'h3F, 7'h3F, 14'h0F81};  // 63 * 63
    vt[8] = '{1'b1, 7'h7F, 7'h7F, 14'h0001};  // -1 * -1

    rst = 1'b1; en = 1'b1;
    in_valid0 = 1'b0; tc0 = 1'b0; a0 = '0; b0 = '0; tag0 = '0;
    in_valid1 = 1'b0; tc1 = 1'b0; a1 = '0; b1 = '0; tag1 = '0;
    in_valid2 = 1'b0; tc2 = 1'b0; a2 = '0; b2 = '0; tag2 = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_out_valid", out_valid0 == 1'b0, 32'(out_valid0), 32'h0);
    check("reset_p", p0 == 14'h0, 32'(p0), 32'h0);
    check("reset_out_tag", out_tag0 == 4'h0, 32'(out_tag0), 32'h0);
    check("reset_sweep_valid", {out_valid1, out_valid2} == 2'b00,
          32'({out_valid1, out_valid2}), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < 9; i++) d0_op(1'b1, vt[i].tc, vt[i].a, vt[i].b, 4'(i), 32'(vt[i].exp));
    idle(1);
    drain();

    for (int tcv = 1; tcv >= 0; tcv--)
      for (int a = 0; a < 128; a++)
        for (int b = 0; b < 128; b++)
          d0_op(1'b1, tcv[0], 7'(a), 7'(b), 4'(a ^ b), ref_mul(7, 7, tcv[0], 32'(a), 32'(b)));
    idle(1);
    drain();

    // Mixed modes back to back.
    d0_op(1'b1, 1'b1, 7'h7F, 7'h7F, 4'h5, 32'd1);
    d0_op(1'b1, 1'b0, 7'h7F, 7'h7F, 4'h6, 32'd16129);
    idle(1);
    drain();

    // Stall with the first result on the output: everything must freeze.
    d0_op(1'b1, 1'b1, 7'h03, 7'h7E, 4'h1, 32'h3FFA);
    d0_op(1'b1, 1'b0, 7'h0A, 7'h0B, 4'h2, 32'd110);
    d0_op(1'b1, 1'b1, 7'h40, 7'h7F, 4'h3, 32'd64);
    idle(1);
    repeat (5) @(posedge clk);
    #1;
    en = 1'b0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      check("stall_out_valid", out_valid0 == 1'b1, 32'(out_valid0), 32'h1);
      check("stall_p", p0 == 14'h3FFA, 32'(p0), 32'h3FFA);
      check("stall_out_tag", out_tag0 == 4'h1, 32'(out_tag0), 32'h1);
    end
    en = 1'b1;
    drain();

    // Bubble pattern 1,0,1.
    d0_op(1'b1, 1'b0, 7'h03, 7'h05, 4'h7, 32'd15);
    d0_op(1'b0, 1'b0, 7'h7F, 7'h7F, 4'hF, 32'd0);
    d0_op(1'b1, 1'b0, 7'h09, 7'h09, 4'h8, 32'd81);
    idle(1);
    drain();

    // Reset with four operations in flight: none may ever emerge.
    for (int i = 0; i < 4; i++) d0_op(1'b1, 1'b0, 7'(i + 2), 7'h11, 4'(i + 10), 32'((i + 2) * 17));
    @(posedge clk);
    #1;
    rst = 1'b1; in_valid0 = 1'b0;
    q0.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid0 == 1'b0, 32'(out_valid0), 32'h0);
    check("midrst_p", p0 == 14'h0, 32'(p0), 32'h0);
    check("midrst_out_tag", out_tag0 == 4'h0, 32'(out_tag0), 32'h0);
    idle(12);
    d0_op(1'b1, 1'b1, 7'h7D, 7'h05, 4'h9, 32'h3FF1);  // -3 * 5
    idle(1);
    drain();

    // Parameter sweep: boundary pairs first, then random mixed-mode traffic.
    sweep_op(1'b1, 32'hFFFF_F808, 32'hFFFF_FF04, 4'h1);
    sweep_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2);
    sweep_op(1'b1, 32'h0000_0800, 32'h0000_0004, 4'h3);
    for (int i = 0; i < 300; i++)
      sweep_op(1'($urandom_range(1)), $urandom, $urandom, 4'($urandom));
    idle(1);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
